fp_writeback_unit: RTL

- Write-side front end for the FP register file.
- Accepts results from two FP functional units (multiplier, adder) over valid/ready handshakes and buffers them per source.
- Arbitrates round-robin onto the single register-file write port (Reg_write / wr_adder / wr_data).
- Keeps a 32-entry busy scoreboard so decode can stall on RAW hazards against in-flight FP destinations.

---
 rtl/fp_writeback_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fp_writeback_unit.sv
// FP writeback front end: buffers multiplier/adder results in small per-source
// FIFOs, arbitrates them round-robin onto the single register-file write port,
// and keeps a busy scoreboard of in-flight FP destinations for RAW stalls.
module fp_writeback_unit #(
   parameter int V     = 32,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         issue_valid,
   input  logic [4:0]   issue_rd,
   input  logic [4:0]   rsf1,
   input  logic [4:0]   rsf2,
   output logic         hazard1,
   output logic         hazard2,
   input  logic         mul_valid,
   output logic         mul_ready,
   input  logic [4:0]   mul_rd,
   input  logic [V-1:0] mul_data,
   input  logic         add_valid,
   output logic         add_ready,
   input  logic [4:0]   add_rd,
   input  logic [V-1:0] add_data,
   output logic         Reg_write,
   output logic [4:0]   wr_adder,
   output logic [V-1:0] wr_data,
   output logic [31:0]  busy
);

   localparam int AW   = $clog2(DEPTH);
   localparam int NSRC = 2;   // source 0 = multiplier, source 1 = adder

   logic [NSRC-1:0] src_valid;
   logic [NSRC-1:0] src_ready;
   logic [NSRC-1:0] src_nonempty;
   logic [NSRC-1:0] src_pop;
   logic [4:0]      src_rd    [NSRC];
   logic [V-1:0]    src_data  [NSRC];
   logic [4:0]      head_rd   [NSRC];
   logic [V-1:0]    head_data [NSRC];

   assign src_valid   = {add_valid, mul_valid};
   assign src_rd[0]   = mul_rd;
   assign src_rd[1]   = add_rd;
   assign src_data[0] = mul_data;
   assign src_data[1] = add_data;
   assign mul_ready   = src_ready[0];
   assign add_ready   = src_ready[1];

   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_fifo
         // Extra MSB on each pointer separates full from empty.
         logic [AW:0]    wr_ptr_reg;
         logic [AW:0]    rd_ptr_reg;
         logic [4:0]     rd_mem   [DEPTH];
         logic [V-1:0]   data_mem [DEPTH];
         logic           full;
         logic           push;

         assign full = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
         assign src_nonempty[gi] = (wr_ptr_reg != rd_ptr_reg);
         // Full blocks acceptance even on a pop edge: no same-edge pass-through.
         assign src_ready[gi]    = !rst && !full;
         assign push             = src_valid[gi] && src_ready[gi];
         assign head_rd[gi]      = rd_mem[rd_ptr_reg[AW-1:0]];
         assign head_data[gi]    = data_mem[rd_ptr_reg[AW-1:0]];

         // Result storage; contents are don't-care while the pointers say empty.
         always_ff @(posedge clk) begin
            if (push) begin
               rd_mem[wr_ptr_reg[AW-1:0]]   <= src_rd[gi];
               data_mem[wr_ptr_reg[AW-1:0]] <= src_data[gi];
            end
         end

         // Pointer advance on push/pop; reset discards everything buffered.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
            end else begin
               if (push)
                  wr_ptr_reg <= wr_ptr_reg + 1'b1;
               if (src_pop[gi])
                  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
         end
      end
   endgenerate

   // Round-robin state: 0 means the multiplier wins the next contested pop.
   logic rr_reg;
   logic both_pending;
   logic sel;
   logic pop_any;

   assign both_pending = &src_nonempty;
   assign pop_any      = |src_nonempty;
   assign sel          = both_pending ? rr_reg : src_nonempty[1];
   assign src_pop      = pop_any ? (sel ? 2'b10 : 2'b01) : 2'b00;

   logic         reg_write_reg;
   logic [4:0]   wr_adder_reg;
   logic [V-1:0] wr_data_reg;
   logic [31:0]  busy_reg;
   logic [31:0]  busy_next;

   // Pointer flips only when both sources competed for the port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_reg <= 1'b0;
      else if (both_pending)
         rr_reg <= ~rr_reg;
   end

   // Write-port register: rd=0 results are consumed but never enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_reg <= 1'b0;
         wr_adder_reg  <= '0;
         wr_data_reg   <= '0;
      end else if (pop_any) begin
         reg_write_reg <= (head_rd[sel] != 5'd0);
         wr_adder_reg  <= head_rd[sel];
         wr_data_reg   <= head_data[sel];
      end else begin
         reg_write_reg <= 1'b0;
      end
   end

   // Scoreboard update: clear on the capture edge, then set on issue so set wins.
   always_comb begin
      busy_next = busy_reg;
      if (reg_write_reg)
         busy_next[wr_adder_reg] = 1'b0;
      if (issue_valid && (issue_rd != 5'd0))
         busy_next[issue_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy_reg <= '0;
      else
         busy_reg <= busy_next;
   end

   assign Reg_write = reg_write_reg;
   assign wr_adder  = wr_adder_reg;
   assign wr_data   = wr_data_reg;
   assign busy      = busy_reg;
   assign hazard1   = (rsf1 != 5'd0) && busy_reg[rsf1];
   assign hazard2   = (rsf2 != 5'd0) && busy_reg[rsf2];

endmodule
